// File: rtl/ysyx_25020037_axi_rd_rsp_if.sv
// AXI4 read address / read data channel bundle between a read master
// and the ysyx_25020037_axi_rd_rsp responder.
interface ysyx_25020037_axi_rd_rsp_if;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst, rready,
        input  arready, rvalid, rdata, rresp, rlast, rid
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
        output arready, rvalid, rdata, rresp, rlast, rid
    );
endinterface

// File: rtl/ysyx_25020037_axi_rd_rsp.sv
// AXI4 read-only responder over a backdoor-loaded word array, one burst at a time.
// Define YSYX_25020037_AXI_RSP_BEAT_GAP_EN to idle rvalid one cycle between beats.
module ysyx_25020037_axi_rd_rsp #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned LATENCY   = 2
) (
    input logic                             clk,
    input logic                             rst,
    ysyx_25020037_axi_rd_rsp_if.slave       bus,
    input logic                             bd_wen,
    input logic [31:0]                      bd_waddr,
    input logic [31:0]                      bd_wdata
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(DEPTH * 4);

    typedef enum logic [1:0] {IDLE, WAIT, DATA} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  id_q, id_d;
    logic [7:0]  len_q, len_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  burst_q, burst_d;
    logic [7:0]  lat_q, lat_d;
    logic [7:0]  beat_q, beat_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        rlast_q, rlast_d;

    logic [31:0] mem [DEPTH];

    logic [7:0]  sel_beat;
    logic        load_beat;
    logic [31:0] beat_addr;
    logic [31:0] beat_off;
    logic [31:0] beat_data;
    logic [1:0]  beat_resp;
    logic [31:0] bd_off;
    logic        unused_ok;

    assign bd_off    = bd_waddr - BASE_ADDR;
    assign unused_ok = ^{beat_off[1:0], bd_off[1:0]};

    always_ff @(posedge clk) begin
        if (bd_wen && bd_off < SPAN) begin
            mem[bd_off[AW+1:2]] <= bd_wdata;
        end
    end

    // Response of the beat selected by sel_beat, from the latched request.
    always_comb begin
        beat_addr = addr_q;
        if (burst_q == 2'd1) begin
            beat_addr = addr_q + {22'd0, sel_beat, 2'b00};
        end
        beat_off  = beat_addr - BASE_ADDR;
        beat_resp = 2'b00;
        beat_data = mem[beat_off[AW+1:2]];
        if (size_q != 3'd2 || burst_q[1] || len_q > 8'd15) begin
            beat_resp = 2'b10;
            beat_data = 32'd0;
        end else if (beat_off >= SPAN) begin
            beat_resp = 2'b11;
            beat_data = 32'd0;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        id_d      = id_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        lat_d     = lat_q;
        beat_d    = beat_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        sel_beat  = beat_q;
        load_beat = 1'b0;
        unique case (state_q)
            IDLE: begin
                arready_d = 1'b1;
                if (bus.arvalid && arready_q) begin
                    addr_d    = bus.araddr;
                    id_d      = bus.arid;
                    len_d     = bus.arlen;
                    size_d    = bus.arsize;
                    burst_d   = bus.arburst;
                    lat_d     = 8'(LATENCY - 1);
                    beat_d    = 8'd0;
                    arready_d = 1'b0;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (lat_q == 8'd0) begin
                    load_beat = 1'b1;
                    state_d   = DATA;
                end else begin
                    lat_d = lat_q - 8'd1;
                end
            end
            DATA: begin
                // rvalid low inside DATA only happens in the inter-beat gap
                if (!rvalid_q) begin
                    load_beat = 1'b1;
                end else if (bus.rready) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        beat_d   = beat_q + 8'd1;
                        sel_beat = beat_q + 8'd1;
`ifdef YSYX_25020037_AXI_RSP_BEAT_GAP_EN
                        rvalid_d = 1'b0;
`else
                        load_beat = 1'b1;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load_beat) begin
            rvalid_d = 1'b1;
            rdata_d  = beat_data;
            rresp_d  = beat_resp;
            rlast_d  = (sel_beat == len_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= 32'd0;
            id_q      <= 4'd0;
            len_q     <= 8'd0;
            size_q    <= 3'd0;
            burst_q   <= 2'd0;
            lat_q     <= 8'd0;
            beat_q    <= 8'd0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'd0;
            rresp_q   <= 2'd0;
            rlast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            id_q      <= id_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            lat_q     <= lat_d;
            beat_q    <= beat_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

    assign bus.arready = arready_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign bus.rlast   = rlast_q;
    assign bus.rid     = id_q;
endmodule

// File: tb/tb_ysyx_25020037_axi_rd_rsp.sv
// Scoreboard bench for ysyx_25020037_axi_rd_rsp: directed cases then
// randomized bursts against a word-array reference model.
module tb_ysyx_25020037_axi_rd_rsp;
    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam int unsigned LAT   = 2;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bd_wen;
    logic [31:0] bd_waddr;
    logic [31:0] bd_wdata;

    ysyx_25020037_axi_rd_rsp_if bus ();

    ysyx_25020037_axi_rd_rsp #(
        .DEPTH(DEPTH),
        .BASE_ADDR(BASE),
        .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .bd_wen(bd_wen),
        .bd_waddr(bd_waddr),
        .bd_wdata(bd_wdata)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [31:0] mem_m [DEPTH];
    beat_t       exp_q [$];
    int          rr_mode = 0;
    int          rr_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    always @(posedge clk) begin
        #1;
        rr_cnt++;
        case (rr_mode)
            0:       bus.rready = 1'b1;
            1:       bus.rready = (rr_cnt % 3 == 0);
            default: bus.rready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: pops one expectation per accepted beat, checks hold and spacing.
    logic        stall_q;
    logic        nxt_pend;
    logic        ar_pend;
    logic [31:0] sv_data;
    logic [1:0]  sv_resp;
    logic        sv_last;
    logic [3:0]  sv_id;
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            stall_q  = 1'b0;
            nxt_pend = 1'b0;
            ar_pend  = 1'b0;
        end else begin
            if (nxt_pend) begin
`ifdef YSYX_25020037_AXI_RSP_BEAT_GAP_EN
                chk("beat_gap_rvalid", bus.rvalid, 0);
`else
                chk("back_to_back_rvalid", bus.rvalid, 1);
`endif
                nxt_pend = 1'b0;
            end
            if (ar_pend) begin
                chk("arready_after_last", bus.arready, 1);
                ar_pend = 1'b0;
            end
            if (stall_q) begin
                chk("hold_rvalid", bus.rvalid, 1);
                chk("hold_rdata", bus.rdata, sv_data);
                chk("hold_rresp", bus.rresp, sv_resp);
                chk("hold_rlast", bus.rlast, sv_last);
                chk("hold_rid", bus.rid, sv_id);
            end
            stall_q = 1'b0;
            if (bus.rvalid && bus.rready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat: got rdata %h want no beat", bus.rdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("rdata", bus.rdata, e.data);
                    chk("rresp", bus.rresp, e.resp);
                    chk("rlast", bus.rlast, e.last);
                    chk("rid", bus.rid, e.id);
                    if (e.last) ar_pend = 1'b1;
                    else nxt_pend = 1'b1;
                end
            end else if (bus.rvalid) begin
                stall_q = 1'b1;
                sv_data = bus.rdata;
                sv_resp = bus.rresp;
                sv_last = bus.rlast;
                sv_id   = bus.rid;
            end
        end
    end

    task automatic push_expect(input logic [31:0] addr, input logic [3:0] id,
                               input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst);
        for (int n = 0; n <= int'(len); n++) begin
            beat_t       b;
            logic [31:0] a;
            logic [31:0] off;
            a      = (burst == 2'd1) ? addr + 32'(4 * n) : addr;
            off    = a - BASE;
            b.id   = id;
            b.last = (n == int'(len));
            if (size != 3'd2 || burst > 2'd1 || len > 8'd15) begin
                b.resp = 2'b10;
                b.data = 32'd0;
            end else if (off >= 32'(DEPTH * 4)) begin
                b.resp = 2'b11;
                b.data = 32'd0;
            end else begin
                b.resp = 2'b00;
                b.data = mem_m[int'(off >> 2)];
            end
            exp_q.push_back(b);
        end
    endtask

    task automatic bd_write(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] off;
        bd_waddr = addr;
        bd_wdata = data;
        bd_wen   = 1'b1;
        @(posedge clk);
        #1 bd_wen = 1'b0;
        off = addr - BASE;
        if (off < 32'(DEPTH * 4)) mem_m[int'(off >> 2)] = data;
    endtask

    // Issues AR and returns at the negedge where the first beat is visible.
    task automatic issue_ar(input logic [31:0] addr, input logic [3:0] id,
                            input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst);
        int w;
        bus.araddr  = addr;
        bus.arid    = id;
        bus.arlen   = len;
        bus.arsize  = size;
        bus.arburst = burst;
        bus.arvalid = 1'b1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!bus.arready && w < 50);
        if (!bus.arready) begin
            total++;
            bad++;
            $display("FAIL ar_timeout: got arready 0 want 1");
        end
        @(posedge clk);
        #1 bus.arvalid = 1'b0;
        w = 0;
        @(negedge clk);
        while (!bus.rvalid && w < 50) begin
            w++;
            @(negedge clk);
        end
        chk("first_beat_latency", w, LAT);
    endtask

    task automatic wait_done();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 2000) begin
            @(posedge clk);
            w++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL burst_timeout: got %0d beats pending want 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] id,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int mode);
        rr_mode = mode;
        push_expect(addr, id, len, size, burst);
        issue_ar(addr, id, len, size, burst);
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old;
        logic [31:0] a;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          r;
        bus.arvalid = 1'b0;
        bus.araddr  = 32'd0;
        bus.arid    = 4'd0;
        bus.arlen   = 8'd0;
        bus.arsize  = 3'd2;
        bus.arburst = 2'd1;
        bd_wen      = 1'b0;
        bd_waddr    = 32'd0;
        bd_wdata    = 32'd0;
        rst         = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_arready", bus.arready, 0);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_rresp", bus.rresp, 0);
        chk("rst_rlast", bus.rlast, 0);
        chk("rst_rid", bus.rid, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("arready_before_edge", bus.arready, 0);
        @(posedge clk);
        #1;
        chk("arready_first_edge", bus.arready, 1);

        for (int i = 0; i < int'(DEPTH); i++) begin
            bd_write(BASE + 32'(4 * i), $urandom);
        end

        bd_write(32'h3000_0010, 32'hDEAD_BEEF);
        do_read(32'h3000_0010, 4'd9, 8'd0, 3'd2, 2'd0, 0);

        bd_write(32'h3000_0000, 32'd1);
        bd_write(32'h3000_0004, 32'd2);
        bd_write(32'h3000_0008, 32'd3);
        bd_write(32'h3000_000C, 32'd4);
        do_read(32'h3000_0000, 4'd5, 8'd3, 3'd2, 2'd1, 0);
        do_read(32'h3000_0000, 4'd5, 8'd3, 3'd2, 2'd1, 1);

        do_read(BASE + 32'(DEPTH * 4), 4'd1, 8'd1, 3'd2, 2'd1, 0);
        do_read(32'h3000_0000, 4'd2, 8'd0, 3'd2, 2'd2, 0);
        do_read(32'h3000_0000, 4'd3, 8'd0, 3'd1, 2'd1, 0);

        bd_write(BASE + 32'(DEPTH * 4), 32'hBAD0_BAD0);
        do_read(32'h3000_0000, 4'd4, 8'd0, 3'd2, 2'd1, 0);
        do_read(32'h3000_0000, 4'd6, 8'd17, 3'd2, 2'd1, 2);

        // FIXED burst with a backdoor write racing beat 1.
        rr_mode = 0;
        old = mem_m[2];
        exp_q.push_back('{data: old, resp: 2'b00, last: 1'b0, id: 4'd7});
        exp_q.push_back('{data: old, resp: 2'b00, last: 1'b0, id: 4'd7});
        exp_q.push_back('{data: 32'h55, resp: 2'b00, last: 1'b1, id: 4'd7});
        mem_m[2] = 32'h55;
        issue_ar(32'h3000_0008, 4'd7, 8'd2, 3'd2, 2'd0);
`ifdef YSYX_25020037_AXI_RSP_BEAT_GAP_EN
        @(negedge clk);
`endif
        bd_waddr = 32'h3000_0008;
        bd_wdata = 32'h55;
        bd_wen   = 1'b1;
        @(posedge clk);
        #1 bd_wen = 1'b0;
        wait_done();

        // Reset while beat 2 of an 8-beat burst is on the bus.
        rr_mode = 0;
        push_expect(32'h3000_0020, 4'd8, 8'd7, 3'd2, 2'd1);
        issue_ar(32'h3000_0020, 4'd8, 8'd7, 3'd2, 2'd1);
`ifdef YSYX_25020037_AXI_RSP_BEAT_GAP_EN
        repeat (4) @(posedge clk);
`else
        repeat (2) @(posedge clk);
`endif
        #1 rst = 1'b1;
        #1;
        chk("midrst_rvalid", bus.rvalid, 0);
        chk("midrst_arready", bus.arready, 0);
        chk("midrst_beats_left", exp_q.size(), 6);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_arready_pre", bus.arready, 0);
        @(posedge clk);
        #1;
        chk("post_rst_arready", bus.arready, 1);
        do_read(32'h3000_0010, 4'd11, 8'd0, 3'd2, 2'd1, 0);

        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 9);
            if (r <= 6) a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4) + 32'($urandom_range(0, 3));
            else if (r == 7) a = BASE + 32'(DEPTH * 4) - 32'(4 * $urandom_range(0, 4));
            else if (r == 8) a = $urandom;
            else a = BASE - 32'd4;
            len   = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(16, 18))
                                                : 8'($urandom_range(0, 15));
            size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
            r     = $urandom_range(0, 19);
            burst = (r < 9) ? 2'd0 : (r < 18) ? 2'd1 : 2'($urandom_range(2, 3));
            do_read(a, 4'($urandom_range(0, 15)), len, size, burst,
                    $urandom_range(0, 2));
        end

        repeat (3) @(posedge clk);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ysyx_25020037_axi_rd_rsp.md
Name: ysyx_25020037_axi_rd_rsp

Overview:
AXI4 read-only responder (slave) that serves the read-address/read-data channels issued by the core's fetch and load masters. Backed by an internal word array: boot ROM model, or SDRAM-like burst target in the SoC-less sim flow. Supports single-beat and FIXED/INCR bursts up to 16 beats, with a programmable first-beat latency. Handles one transaction at a time. A backdoor write port loads the image.

Parameters:
DEPTH, 1024, memory depth in 32-bit words (power of 2)
BASE_ADDR, 32'h3000_0000, byte address of word 0
LATENCY, 2, cycles from AR handshake to first rvalid (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
arvalid  in  1  read address valid
arready  out  1  read address ready
araddr  in  32  byte address of first beat
arid  in  4  transaction ID
arlen  in  8  beats minus 1
arsize  in  3  beat size; only 3'h2 supported
arburst  in  2  0=FIXED, 1=INCR, others unsupported
rvalid  out  1  read data valid
rready  in  1  read data ready
rdata  out  32  read data
rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
rlast  out  1  final beat of burst
rid  out  4  echoed arid
bd_wen  in  1  backdoor write enable
bd_waddr  in  32  backdoor byte address (word aligned)
bd_wdata  in  32  backdoor write data

Behaviour:
- Reset values: arready=0, rvalid=0, rdata=0, rresp=0, rlast=0, rid=0, state=IDLE, counters=0. Memory contents are not reset.
- Reset asserted mid-transaction: the transaction is dropped with no further beats. After release, the block is in IDLE and arready=1 on the first clock edge.
- FSM states: IDLE, WAIT, DATA.
- IDLE:
  - arready=1.
  - On arvalid&arready, latch araddr, arid, arlen, arburst, arsize.
  - Load the latency counter with LATENCY-1, drop arready, go to WAIT.
- WAIT:
  - Decrement the counter.
  - At 0, present beat 0: rvalid=1, rdata, rresp and rlast are registered, and the state goes to DATA.
  - With LATENCY=1, rvalid rises on the cycle after the AR handshake.
- DATA:
  - rvalid, rdata, rresp, rlast and rid stay stable until rready.
  - On rvalid&rready with rlast=1: rvalid=0, rlast=0, go to IDLE. arready returns to 1 on the next cycle, so there is a minimum of 1 idle cycle between transactions.
  - On rvalid&rready otherwise: the beat counter increments and the next beat is presented on the following cycle, so back-to-back beats are possible.
- Beat address:
  - INCR: addr_n = addr_0 + 4*n, with 32-bit wraparound and no 4KB-boundary check.
  - FIXED: every beat uses addr_0.
- Per-beat response, first matching rule wins:
  - arsize!=2 or arburst not in {0,1}: rresp=10, rdata=0.
  - (addr-BASE_ADDR) >= DEPTH*4 as unsigned: rresp=11, rdata=0.
  - Otherwise rresp=00 and rdata=mem[(addr-BASE_ADDR)>>2].
  - The low 2 address bits are ignored.
  - Burst length is always honoured: arlen+1 beats are always sent, even on error.
- rlast=1 exactly on beat arlen. arlen>15: rresp=10 on all beats, still arlen+1 beats.
- rid equals the latched arid for all beats.
- Backdoor write:
  - When bd_wen=1 and the address is in range, the word is written at the clock edge. Out-of-range writes are ignored.
  - A write in the same cycle a beat is registered from the same word: the beat carries the old data.
  - Backdoor writes are legal in any state.
- arvalid asserted outside IDLE is not accepted (arready=0). The master must hold it.

Optional Feature:
- Macro: YSYX_25020037_AXI_RSP_BEAT_GAP_EN
- Defined: after each accepted non-last beat, rvalid is held at 0 for exactly 1 cycle before the next beat. This models SDRAM column-access gaps. Total burst time is at least LATENCY + 2*(arlen+1) - 1 cycles.
- Undefined: beats are back-to-back as above.

Test Plan:
- Single beat: bd write 0x3000_0010=0xDEADBEEF. AR addr=0x3000_0010, len=0, burst=0, rready=1, LATENCY=2. Expect rvalid 2 cycles after the handshake, rdata=0xDEADBEEF, rresp=00, rlast=1, rid=arid.
- INCR burst: preload 0x3000_0000..0C = 1,2,3,4. AR len=3, burst=1, id=5, rready=1. Expect 4 consecutive beats 1,2,3,4, rlast only on the 4th, rid=5, then arready=1 one cycle later.
- Backpressure: same burst with rready toggling 1,0,0,1,... Expect rdata/rlast stable while rready=0, beat order preserved, no beats lost or duplicated.
- Errors:
  - addr=BASE_ADDR+DEPTH*4, len=1: 2 beats with rresp=11, rdata=0.
  - arburst=2, len=0: 1 beat with rresp=10.
  - arsize=1: rresp=10.
- FIXED burst and hazard: AR addr=0x3000_0008, len=2, burst=0. Expect 3 beats with the same word. Pulse bd_wen to that word with 0x55 while beat 1 is registered: beat 1 carries the old value, beat 2 carries 0x55.
- Reset mid-burst: assert rst during beat 2 of a len=7 burst. Expect rvalid=0 and arready=0 immediately. After release, arready=1 and a new single-beat read completes correctly. With BEAT_GAP_EN, also check the 1-cycle rvalid gap between beats.
